// File: rtl/core_mem_pkg.sv
// Shared encodings and helpers for the core-to-bus memory port.
// Size codes, FSM states, byte-enable width and the store lane/enable helpers.
package core_mem_pkg;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte offset actually used on the bus: low bits a size cannot address are forced to 0.
  function automatic logic [1:0] eff_offset(input size_e sz, input logic [1:0] off);
    case (sz)
      SIZE_BYTE: eff_offset = off;
      SIZE_HALF: eff_offset = {off[1], 1'b0};
      default:   eff_offset = 2'b00;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_en(input size_e sz, input logic [1:0] off);
    case (sz)
      SIZE_BYTE: byte_en = 4'b0001 << off;
      SIZE_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default:   byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input size_e sz, input logic [31:0] wdata);
    case (sz)
      SIZE_BYTE: lane_rep = {4{wdata[7:0]}};
      SIZE_HALF: lane_rep = {2{wdata[15:0]}};
      default:   lane_rep = wdata;
    endcase
  endfunction

endpackage

// File: rtl/core_mem_load_align.sv
// Load data alignment: shifts the addressed lane down, truncates to the access
// size and zero- or sign-extends to 32 bits. Purely combinational.
module mem_load_align
  import core_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size_e'(size))
      SIZE_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/core_mem_port.sv
// Single-outstanding core-to-bus memory port (IDLE -> BUS -> RESP) with optional
// watchdog. Define MEM_PORT_MISALIGN_TRAP_EN to error on misaligned half/word accesses.
module core_mem_port
  import core_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int          CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TO_LAST   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);
  localparam bit          WDOG_EN   = (TIMEOUT_CYC > 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  size_e               req_sz;
  logic [1:0]          req_off;
  logic                trap;
  logic [31:0]         load_data;

  assign req_sz  = size_e'(req_size);
  assign req_off = eff_offset(req_sz, req_addr[1:0]);

`ifdef MEM_PORT_MISALIGN_TRAP_EN
  assign trap = (req_sz == SIZE_HALF && req_addr[0]) ||
                (req_sz == SIZE_WORD && req_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  mem_load_align u_load_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (off_q),
    .rdata       (mem_rdata),
    .data        (load_data)
  );

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          be_d    = byte_en(req_sz, req_off);
          wdata_d = lane_rep(req_sz, req_wdata);
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_off;
          rdata_d = '0;
          if (req_sz == SIZE_RSVD || trap) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // mem_ready wins over an expiring watchdog in the same cycle.
        if (mem_ready) begin
          rdata_d = we_q ? 32'h0 : load_data;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (WDOG_EN && cnt_q == TO_LAST_C) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: data/address registers are reset too, since they drive the bus outputs directly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_valid = (state_q == ST_BUS);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_core_mem_port.sv
// Directed bench for core_mem_port (TIMEOUT_CYC = 8); expectations follow
// MEM_PORT_MISALIGN_TRAP_EN when it is defined for the build.
module tb_core_mem_port;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the last do_txn call.
  logic [31:0] g_addr, g_wdata, g_rdata;
  logic [3:0]  g_be;
  logic        g_we, g_err, g_stable, g_rsp_seen, g_busy_ready, g_rsp_after;
  int          g_bus, g_rsp_cyc;

  always #5 clk = ~clk;

  core_mem_port #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Issue one request and play the bus: mem_ready in bus cycle index 'waits' (-1 = never).
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    g_bus = 0; g_stable = 1'b1; g_rsp_seen = 1'b0; g_busy_ready = 1'b0;
    g_rsp_cyc = 0; g_err = 1'bx; g_rdata = 'x;
    g_addr = 'x; g_be = 'x; g_wdata = 'x; g_we = 1'bx;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (rsp_valid) begin
        g_rsp_seen = 1'b1; g_rsp_cyc = c; g_err = rsp_err; g_rdata = rsp_rdata;
        if (req_ready || mem_valid) g_busy_ready = 1'b1;
        break;
      end
      if (req_ready) g_busy_ready = 1'b1;
      if (mem_valid) begin
        if (g_bus == 0) begin
          g_addr = mem_addr; g_be = mem_be; g_wdata = mem_wdata; g_we = mem_we;
        end else if (mem_addr !== g_addr || mem_be !== g_be ||
                     mem_wdata !== g_wdata || mem_we !== g_we) begin
          g_stable = 1'b0;
        end
        if (g_bus == waits) begin mem_ready = 1'b1; mem_rdata = rd; end
        g_bus++;
      end
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = 32'h5555_AAAA;
    end
    @(negedge clk);
    g_rsp_after = rsp_valid;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got v=%b e=%b exp 0/0", rsp_valid, rsp_err); end
    n_tests++; if (mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rsp_rdata !== 32'h0)
      begin n_fail++; $display("FAIL reset_data got be=%h a=%h wd=%h rd=%h exp 0", mem_be, mem_addr, mem_wdata, rsp_rdata); end
    resetn = 1'b1;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word_load();
    do_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    n_tests++; if (g_be !== 4'hF || g_addr !== 32'h100 || g_we !== 1'b0) begin n_fail++; $display("FAIL word_load_bus got be=%h a=%h we=%b exp F/100/0", g_be, g_addr, g_we); end
    n_tests++; if (g_rsp_cyc !== 2) begin n_fail++; $display("FAIL word_load_latency got N+%0d exp N+2", g_rsp_cyc); end
    n_tests++; if (g_rdata !== 32'hDEADBEEF || g_err !== 1'b0) begin n_fail++; $display("FAIL word_load_rsp got %h err=%b exp deadbeef/0", g_rdata, g_err); end
    n_tests++; if (g_busy_ready !== 1'b0 || g_rsp_after !== 1'b0) begin n_fail++; $display("FAIL word_load_handshake got busy_ready=%b rsp_after=%b exp 0/0", g_busy_ready, g_rsp_after); end
  endtask

  task automatic test_byte_half_load();
    do_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80112233);
    n_tests++; if (g_be !== 4'h8 || g_addr !== 32'h100) begin n_fail++; $display("FAIL sbyte_bus got be=%h a=%h exp 8/100", g_be, g_addr); end
    n_tests++; if (g_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL sbyte_data got %h exp ffffff80", g_rdata); end
    do_txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80112233);
    n_tests++; if (g_rdata !== 32'h00000080) begin n_fail++; $display("FAIL ubyte_data got %h exp 00000080", g_rdata); end
    do_txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1, 32'h80011234);
    n_tests++; if (g_be !== 4'hC || g_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL shalf got be=%h d=%h exp c/ffff8001", g_be, g_rdata); end
  endtask

  task automatic test_store();
    do_txn(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h12345678);
    n_tests++; if (g_wdata !== 32'hABCDABCD || g_be !== 4'hC || g_addr !== 32'h200 || g_we !== 1'b1)
      begin n_fail++; $display("FAIL half_store_bus got wd=%h be=%h a=%h we=%b exp abcdabcd/c/200/1", g_wdata, g_be, g_addr, g_we); end
    n_tests++; if (g_bus !== 4 || g_stable !== 1'b1) begin n_fail++; $display("FAIL half_store_hold got cycles=%0d stable=%b exp 4/1", g_bus, g_stable); end
    n_tests++; if (g_rsp_seen !== 1'b1 || g_err !== 1'b0 || g_rdata !== 32'h0) begin n_fail++; $display("FAIL half_store_rsp got seen=%b err=%b rd=%h exp 1/0/0", g_rsp_seen, g_err, g_rdata); end
    do_txn(1'b1, 2'b00, 1'b0, 32'h101, 32'h1234565A, 0, 32'h0);
    n_tests++; if (g_wdata !== 32'h5A5A5A5A || g_be !== 4'h2) begin n_fail++; $display("FAIL byte_store got wd=%h be=%h exp 5a5a5a5a/2", g_wdata, g_be); end
  endtask

  task automatic test_watchdog();
    do_txn(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, -1, 32'h0);
    n_tests++; if (g_bus !== 8) begin n_fail++; $display("FAIL timeout_cycles got %0d exp 8", g_bus); end
    n_tests++; if (g_rsp_seen !== 1'b1 || g_err !== 1'b1 || g_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_rsp got seen=%b err=%b rd=%h exp 1/1/0", g_rsp_seen, g_err, g_rdata); end
    do_txn(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 7, 32'hCAFEF00D);
    n_tests++; if (g_bus !== 8 || g_err !== 1'b0 || g_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ready_at_expiry got cycles=%0d err=%b rd=%h exp 8/0/cafef00d", g_bus, g_err, g_rdata); end
  endtask

  task automatic test_errors();
    do_txn(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 0, 32'h0);
    n_tests++; if (g_bus !== 0 || g_err !== 1'b1 || g_rsp_cyc !== 1) begin n_fail++; $display("FAIL rsvd_size got cycles=%0d err=%b lat=%0d exp 0/1/1", g_bus, g_err, g_rsp_cyc); end
    do_txn(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h11223344);
`ifdef MEM_PORT_MISALIGN_TRAP_EN
    n_tests++; if (g_bus !== 0 || g_err !== 1'b1 || g_rdata !== 32'h0) begin n_fail++; $display("FAIL misalign_trap got cycles=%0d err=%b rd=%h exp 0/1/0", g_bus, g_err, g_rdata); end
`else
    n_tests++; if (g_addr !== 32'h100 || g_be !== 4'hF || g_err !== 1'b0 || g_rdata !== 32'h11223344)
      begin n_fail++; $display("FAIL misalign_word got a=%h be=%h err=%b rd=%h exp 100/f/0/11223344", g_addr, g_be, g_err, g_rdata); end
`endif
  endtask

  task automatic test_ready_idle();
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_in_idle got rsp=%b mv=%b rr=%b exp 0/0/1", rsp_valid, mem_valid, req_ready); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h500; req_wdata = 32'h01020304;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL midbus_enter got mv=%b exp 1", mem_valid); end
    resetn = 1'b0;
    @(negedge clk);
    n_tests++; if (mem_valid !== 1'b0 || rsp_valid !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      begin n_fail++; $display("FAIL midbus_reset got mv=%b rsp=%b be=%h a=%h wd=%h exp 0", mem_valid, rsp_valid, mem_be, mem_addr, mem_wdata); end
    resetn = 1'b1;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL midbus_after got rsp=%b rr=%b exp 0/1", rsp_valid, req_ready); end
    do_txn(1'b0, 2'b01, 1'b1, 32'h602, 32'h0, 2, 32'h9ABC0000);
    n_tests++; if (g_err !== 1'b0 || g_rdata !== 32'h00009ABC || g_be !== 4'hC) begin n_fail++; $display("FAIL midbus_next got err=%b rd=%h be=%h exp 0/00009abc/c", g_err, g_rdata, g_be); end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0; resetn = 1'b0;
    test_reset();
    test_word_load();
    test_byte_half_load();
    test_store();
    test_watchdog();
    test_errors();
    test_ready_idle();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
